// File: rtl/demux_stream.sv
// Registered 1-to-NCH stream demultiplexer with per-channel one-entry output
// registers, broadcast mode and a saturating count of out-of-range drops.
module demux_stream #(
    parameter int unsigned width = 8,
    parameter int unsigned snum  = 3,
    parameter int unsigned NCH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [width-1:0]     i,
    input  logic [snum-1:0]      sel,
    input  logic                 bcast,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic [NCH*width-1:0] o,
    output logic [NCH-1:0]       o_valid,
    input  logic [NCH-1:0]       o_ready,
    output logic                 err,
    output logic [7:0]           err_cnt
);

    logic [NCH-1:0] can_acc;
    logic [NCH-1:0] sel_hit;
    logic [NCH-1:0] load;
    logic           in_range;
    logic           xfer;
    logic           drop;

    // A full register that drains this cycle may reload in the same cycle.
    assign can_acc = ~o_valid | o_ready;

    always_comb begin
        sel_hit = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            sel_hit[k] = (32'(sel) == k);
        end
    end

    assign in_range = |sel_hit;

    always_comb begin
        if (bcast) begin
            i_ready = &can_acc;
        end else if (in_range) begin
            i_ready = |(sel_hit & can_acc);
        end else begin
            i_ready = 1'b1;
        end
    end

    assign xfer = i_valid && i_ready;
    assign load = !xfer ? '0 : (bcast ? '1 : sel_hit);
    assign drop = xfer && !bcast && !in_range;

    // Load takes priority over drain, so a simultaneous drain and load leaves no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o       <= '0;
            o_valid <= '0;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (load[k]) begin
                    o[k*width +: width] <= i;
                    o_valid[k]          <= 1'b1;
                end else if (o_ready[k]) begin
                    o_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= drop;
            if (drop && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream: the driver predicts acceptance and pushes
// expected words per channel; a negedge monitor pops them on output transfers.
module tb_demux_stream;

    localparam int W = 8;
    localparam int S = 3;
    localparam int N = 6;

    typedef logic [W-1:0] q_t[$];

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   i;
    logic [S-1:0]   sel;
    logic           bcast;
    logic           i_valid;
    logic           i_ready;
    logic [N*W-1:0] o;
    logic [N-1:0]   o_valid;
    logic [N-1:0]   o_ready;
    logic           err;
    logic [7:0]     err_cnt;

    always #5 clk = ~clk;

    demux_stream #(.width(W), .snum(S), .NCH(N)) dut (
        .clk(clk), .rst_n(rst_n), .i(i), .sel(sel), .bcast(bcast),
        .i_valid(i_valid), .i_ready(i_ready), .o(o), .o_valid(o_valid),
        .o_ready(o_ready), .err(err), .err_cnt(err_cnt)
    );

    int       n_vec = 0;
    int       n_bad = 0;
    q_t       exp_q[N];
    logic [W-1:0] last_val[N];
    logic     err_expect = 1'b0;
    int       cnt_expect = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are stable mid-cycle; pops happen before the driver's model step.
    always @(negedge clk) begin
        logic [N-1:0]   ev;
        logic [N*W-1:0] eo;
        logic [W-1:0]   w;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                ev[k]        = (exp_q[k].size() != 0);
                eo[k*W +: W] = last_val[k];
            end
            chk("o_valid", 64'(o_valid), 64'(ev));
            chk("o_data", 64'(o), 64'(eo));
            chk("err", 64'(err), 64'(err_expect));
            chk("err_cnt", 64'(err_cnt), 64'(cnt_expect));
            for (int k = 0; k < N; k++) begin
                if (exp_q[k].size() != 0 && o_ready[k]) begin
                    w = exp_q[k].pop_front();
                    chk($sformatf("drain_ch%0d", k), 64'(o[k*W +: W]), 64'(w));
                end
            end
        end
    end

    // Reference: a channel accepts iff its expected queue is empty after this cycle's drain.
    task automatic model_in();
        logic [N-1:0] can;
        logic         pred;
        for (int k = 0; k < N; k++) can[k] = (exp_q[k].size() == 0);
        if (bcast)            pred = &can;
        else if (int'(sel) < N) pred = can[sel];
        else                  pred = 1'b1;
        chk("i_ready", 64'(i_ready), 64'(pred));
        err_expect = 1'b0;
        if (i_valid && pred) begin
            if (bcast) begin
                for (int k = 0; k < N; k++) begin
                    exp_q[k].push_back(i);
                    last_val[k] = i;
                end
            end else if (int'(sel) < N) begin
                exp_q[sel].push_back(i);
                last_val[sel] = i;
            end else begin
                err_expect = 1'b1;
                if (cnt_expect < 255) cnt_expect++;
            end
        end
    endtask

    task automatic step(input logic v, input logic [S-1:0] s, input logic b,
                        input logic [N-1:0] r, input logic [W-1:0] d);
        @(posedge clk);
        #1;
        i_valid = v;
        sel     = s;
        bcast   = b;
        o_ready = r;
        i       = d;
        @(negedge clk);
        #1;
        model_in();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("rst_o", 64'(o), 64'd0);
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        for (int k = 0; k < N; k++) begin
            exp_q[k].delete();
            last_val[k] = '0;
        end
        cnt_expect = 0;
        err_expect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i = '0; sel = '0; bcast = 1'b0; i_valid = 1'b0; o_ready = '1;
        for (int k = 0; k < N; k++) last_val[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Traffic with stalled consumers, plus drops, then asynchronous reset.
        for (int k = 0; k < 4; k++) step(1'b1, 3'(k), 1'b0, 6'h00, 8'(8'h10 + k));
        step(1'b1, 3'd7, 1'b0, 6'h00, 8'h99);
        do_reset();
        step(1'b0, 3'd0, 1'b0, 6'h3F, 8'h00);

        // Routing, one word per channel.
        for (int k = 0; k < N; k++) step(1'b1, 3'(k), 1'b0, 6'h3F, 8'(8'hA0 + 16 * k));
        step(1'b0, 3'd0, 1'b0, 6'h3F, 8'h00);

        // Backpressure on channel 2, independent channel 3, drain+load same edge.
        step(1'b1, 3'd2, 1'b0, 6'h3B, 8'hA0);
        step(1'b1, 3'd2, 1'b0, 6'h3B, 8'hB0);
        step(1'b1, 3'd3, 1'b0, 6'h3B, 8'h11);
        step(1'b1, 3'd2, 1'b0, 6'h3F, 8'hB0);
        step(1'b0, 3'd0, 1'b0, 6'h3F, 8'h00);

        // Broadcast blocked by full channel 4, then released.
        step(1'b1, 3'd4, 1'b0, 6'h2F, 8'h55);
        step(1'b1, 3'd0, 1'b1, 6'h2F, 8'hC3);
        step(1'b1, 3'd5, 1'b1, 6'h3F, 8'hC3);
        step(1'b0, 3'd0, 1'b0, 6'h00, 8'h00);
        step(1'b0, 3'd0, 1'b0, 6'h3F, 8'h00);

        // Out-of-range drops and saturation of the drop counter.
        step(1'b1, 3'd6, 1'b0, 6'h3F, 8'h66);
        step(1'b1, 3'd7, 1'b0, 6'h3F, 8'h77);
        step(1'b0, 3'd0, 1'b0, 6'h3F, 8'h00);
        for (int n = 0; n < 300; n++) step(1'b1, 3'(6 + (n % 2)), 1'b0, 6'h3F, 8'(n));
        step(1'b0, 3'd0, 1'b0, 6'h3F, 8'h00);
        step(1'b0, 3'd0, 1'b0, 6'h3F, 8'h00);

        // Reset while channel 1 is full and stalled.
        step(1'b1, 3'd1, 1'b0, 6'h3D, 8'h5A);
        step(1'b0, 3'd1, 1'b0, 6'h3D, 8'h00);
        do_reset();
        step(1'b1, 3'd1, 1'b0, 6'h3F, 8'h88);
        step(1'b0, 3'd0, 1'b0, 6'h3F, 8'h00);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(3) != 0), 3'($urandom_range(7)), ($urandom_range(7) == 0),
                 6'($urandom), 8'($urandom));
        end
        step(1'b0, 3'd0, 1'b0, 6'h3F, 8'h00);
        @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Registered 1-to-NCH demultiplexer with a valid/ready handshake on the input and on every output channel.
- Each channel has a one-entry output register, so a stalled consumer holds only its own channel.
- Supports a broadcast mode that writes one input word to all channels.
- Flags and counts select values that do not map to a channel; used as the stream-level successor of the combinational data-flow demux.

Parameters:
- width, 8, data word width in bits
- snum, 3, select width in bits
- NCH, 8, number of output channels; legal range 2 to 2**snum

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i  input  width  input data word
- sel  input  snum  destination channel index
- bcast  input  1  1 = write word to all channels, sel ignored
- i_valid  input  1  input word present
- i_ready  output  1  block can accept input this cycle (combinational)
- o  output  NCH*width  channel k data in o[k*width +: width]
- o_valid  output  NCH  channel k register holds unconsumed data
- o_ready  input  NCH  consumer k accepts data this cycle
- err  output  1  one-cycle pulse: out-of-range word dropped
- err_cnt  output  8  saturating count of dropped words

Behaviour:
- Reset (rst_n low, asynchronous): o=0, o_valid=0, err=0, err_cnt=0; no transfer is recorded while rst_n is low. Data buffered at reset is lost.
- can_acc[k] = !o_valid[k] || o_ready[k]. A full register that drains this cycle can reload in the same cycle.
- i_ready:
  - bcast=1: &can_acc
  - bcast=0, sel<NCH: can_acc[sel]
  - bcast=0, sel>=NCH: 1
- Input transfer: i_valid && i_ready at the rising edge.
- Output transfer on channel k: o_valid[k] && o_ready[k] at the rising edge.
- Latency: a word accepted at edge n appears on the slice with o_valid[k]=1 after edge n, i.e. one cycle.
- Channel k register, evaluated each edge:
  - loaded (o slice <= i, o_valid[k] <= 1) on an input transfer with (bcast=1) or (bcast=0, sel==k, sel<NCH)
  - else on an output transfer: o_valid[k] <= 0, data slice holds its last value
  - else: hold
- Simultaneous drain and load on channel k: load wins, o_valid[k] stays 1, new data replaces old; no bubble.
- Out of range (bcast=0, sel>=NCH): the input transfer completes and the word is dropped. err=1 for exactly the next cycle. err_cnt increments and saturates at 255; it never wraps. No channel changes.
- Broadcast is all-or-nothing: no channel loads unless every channel can accept. bcast never raises err.
- Combinational path o_ready -> i_ready is intended (no skid buffer). i_valid may depend on i_ready only through registers upstream.
- i, sel and bcast are sampled only on a transfer edge. Changing them while i_valid=1 and i_ready=0 is legal and carries no retention requirement.
- Channels are independent: a stalled channel k never blocks traffic to channel j (j!=k) in non-broadcast mode.
- NCH==2**snum: err never asserts.

Test Plan:
Bench instance: width=8, snum=3, NCH=6.
- Reset: drive traffic, then rst_n=0 asynchronously between edges -> o=0, o_valid=0, err=0, err_cnt=0 immediately, before the next edge; after release i_ready=1.
- Routing: o_ready=6'h3F, i_valid=1, one word per cycle with i=8'hA0,B0,C0,D0,E0,F0 and sel=0..5 -> o_valid[k] high exactly one cycle after each send, slice k = sent value, other channels unchanged.
- Backpressure: o_ready[2]=0, send 8'hA0 to sel=2 -> o_valid[2]=1. Next, 8'hB0 to sel=2 -> i_ready=0 and o holds A0. Send 8'h11 to sel=3 meanwhile -> accepted. Raise o_ready[2] -> same edge drains A0 and loads B0, o_valid[2] stays 1.
- Broadcast: fill channel 4 with o_ready[4]=0, then bcast=1, i=8'hC3 -> i_ready=0 and no channel loads. Raise o_ready[4] -> all six slices =8'hC3 with o_valid=6'h3F, err=0.
- Out of range: sel=6 then sel=7 with bcast=0 -> i_ready=1, err pulses twice, err_cnt=2, o_valid unchanged. Then 300 consecutive dropped words -> err_cnt=255 and holds at 255.
- Reset mid-stall: channel 1 full and stalled, rst_n=0 -> o_valid=0, o=0. After release a new word to sel=1 is accepted with one-cycle latency.
